// File: rtl/tlb_pkg.sv
// Shared TLB types: page-table lo half, full entry, management op encodings,
// FSM states and the VPPN compare helper used by lookups and invalidation walks.
package tlb_pkg;

    localparam int ASID_MAXW = 10;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_2M = 6'd21;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_lo_t;

    typedef struct packed {
        logic                 e;
        logic                 g;
        logic [ASID_MAXW-1:0] asid;
        logic [18:0]          vppn;
        logic [5:0]           ps;
        tlb_lo_t              lo0;
        tlb_lo_t              lo1;
    } tlb_entry_t;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_type_e;

    typedef enum logic [4:0] {
        INV_ALL0      = 5'd0,
        INV_ALL1      = 5'd1,
        INV_GLOBAL    = 5'd2,
        INV_NONGLOBAL = 5'd3,
        INV_ASID      = 5'd4,
        INV_ASID_VA   = 5'd5,
        INV_GASID_VA  = 5'd6
    } inv_op_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INV_WALK = 2'd1,
        S_DONE     = 2'd2
    } tlb_state_e;

    // vppn holds VA[31:13]; a 2M page only compares VA[31:22].
    function automatic logic vppn_match(logic [18:0] ent_vppn, logic [18:0] va_vppn,
                                        logic [5:0] ps);
        if (ps == PS_2M) return ent_vppn[18:9] == va_vppn[18:9];
        return ent_vppn == va_vppn;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// Single-entry TLB match with odd/even page half selection.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int ASIDW = 10
) (
    input  tlb_entry_t       entry,
    input  logic [ASIDW-1:0] asid,
    input  logic [19:0]      va,
    output logic             hit,
    output tlb_lo_t          lo
);

    logic odd;

    // va carries VA[31:12], so VA[12] is va[0] and VA[21] is va[9].
    always_comb begin
        hit = entry.e && (entry.g || (entry.asid[ASIDW-1:0] == asid))
              && vppn_match(entry.vppn, va[19:1], entry.ps);
        odd = (entry.ps == PS_2M) ? va[9] : va[0];
        lo  = odd ? entry.lo1 : entry.lo0;
    end

endmodule

// File: rtl/tlb_param.sv
// Parameterised fully-associative TLB: registered multi-port lookup plus a
// management port for search, read, write, round-robin fill and invalidate walks.
module tlb_param
    import tlb_pkg::*;
#(
    parameter  int NUM_ENTRIES = 64,
    parameter  int NUM_LOOKUP  = 2,
    parameter  int ASIDW       = 10,
    localparam int IDXW        = $clog2(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_LOOKUP-1:0]        lk_valid,
    input  logic [NUM_LOOKUP-1:0][19:0]  lk_va,
    input  logic [ASIDW-1:0]             csr_asid,
    output logic [NUM_LOOKUP-1:0]        lk_rsp_valid,
    output logic [NUM_LOOKUP-1:0]        lk_hit,
    output tlb_lo_t [NUM_LOOKUP-1:0]     lk_lo,
    output logic [NUM_LOOKUP-1:0][5:0]   lk_ps,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2:0]                   op_type,
    input  logic [IDXW-1:0]              op_idx,
    input  tlb_entry_t                   op_entry,
    input  logic [4:0]                   op_inv_op,
    input  logic [ASIDW-1:0]             op_inv_asid,
    input  logic [18:0]                  op_inv_va,
    output logic                         res_valid,
    output logic                         res_hit,
    output logic [IDXW-1:0]              res_idx,
    output tlb_entry_t                   res_entry,
    output logic                         op_err,
    output logic [1:0]                   dbg_state
);

    tlb_state_e state_q, state_d;

    tlb_entry_t             ent_q    [NUM_ENTRIES];
    tlb_entry_t             ent_view [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] e_q;

    logic [IDXW-1:0]  victim_q, walk_ptr_q;
    logic [4:0]       inv_op_q;
    logic [ASIDW-1:0] inv_asid_q;
    logic [18:0]      inv_va_q;
    logic             done_err_q;
    logic             res_valid_q, op_err_q;

    logic            accept, ps_ok, is_fill, wr_en, walk_clr, clr_cond;
    logic            asid_eq, va_eq;
    logic [IDXW-1:0] wr_idx;
    tlb_entry_t      walk_ent;

    // Port NUM_LOOKUP is the SRCH port driven from op_entry.vppn.
    logic [NUM_LOOKUP:0][19:0]      port_va;
    logic                           hit_v [NUM_LOOKUP+1][NUM_ENTRIES];
    tlb_lo_t                        lo_v  [NUM_LOOKUP+1][NUM_ENTRIES];
    logic [NUM_LOOKUP:0]            sel_hit;
    logic [NUM_LOOKUP:0][IDXW-1:0]  sel_idx;
    tlb_lo_t [NUM_LOOKUP:0]         sel_lo;
    logic [NUM_LOOKUP:0][5:0]       sel_ps;

    assign port_va = {{op_entry.vppn, 1'b0}, lk_va};

    // e_q is the resettable valid flag; the stored e bit is kept alongside it.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_view[i]   = ent_q[i];
            ent_view[i].e = ent_q[i].e & e_q[i];
        end
    end

    for (genvar p = 0; p <= NUM_LOOKUP; p++) begin : g_port
        for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
            tlb_match #(.ASIDW(ASIDW)) u_match (
                .entry (ent_view[i]),
                .asid  (csr_asid),
                .va    (port_va[p]),
                .hit   (hit_v[p][i]),
                .lo    (lo_v[p][i])
            );
        end
    end

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        sel_hit = '0;
        sel_idx = '0;
        sel_lo  = '0;
        sel_ps  = '0;
        for (int p = 0; p <= NUM_LOOKUP; p++) begin
            for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
                if (hit_v[p][i]) begin
                    sel_hit[p] = 1'b1;
                    sel_idx[p] = IDXW'(i);
                    sel_lo[p]  = lo_v[p][i];
                    sel_ps[p]  = ent_view[i].ps;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_rsp_valid <= '0;
            lk_hit       <= '0;
            lk_lo        <= '0;
            lk_ps        <= '0;
        end else begin
            for (int p = 0; p < NUM_LOOKUP; p++) begin
                lk_rsp_valid[p] <= lk_valid[p];
                lk_hit[p]       <= lk_valid[p] & sel_hit[p];
                lk_lo[p]        <= (lk_valid[p] && sel_hit[p]) ? sel_lo[p] : '0;
                lk_ps[p]        <= (lk_valid[p] && sel_hit[p]) ? sel_ps[p] : '0;
            end
        end
    end

    // Management handshake: an op is taken on a rising edge where op_valid and
    // op_ready are both high; op_ready drops only while an INV walk is running.
    always_comb begin
        state_d  = state_q;
        op_ready = 1'b1;
        case (state_q)
            S_INV_WALK: begin
                op_ready = 1'b0;
                if (walk_ptr_q == IDXW'(NUM_ENTRIES - 1)) state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                if (op_valid && op_type == OP_INV)
                    state_d = (op_inv_op > INV_OP_MAX) ? S_DONE : S_INV_WALK;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        accept   = op_valid & op_ready;
        ps_ok    = (op_entry.ps == PS_4K) || (op_entry.ps == PS_2M);
        is_fill  = accept && (op_type == OP_FILL);
        wr_en    = (is_fill || (accept && op_type == OP_WR)) && ps_ok;
        wr_idx   = is_fill ? victim_q : op_idx;
        walk_ent = ent_view[walk_ptr_q];
        asid_eq  = walk_ent.asid[ASIDW-1:0] == inv_asid_q;
        va_eq    = vppn_match(walk_ent.vppn, inv_va_q, walk_ent.ps);
        case (inv_op_q)
            INV_ALL0, INV_ALL1: clr_cond = 1'b1;
            INV_GLOBAL:         clr_cond = walk_ent.g;
            INV_NONGLOBAL:      clr_cond = !walk_ent.g;
            INV_ASID:           clr_cond = !walk_ent.g && asid_eq;
            INV_ASID_VA:        clr_cond = !walk_ent.g && asid_eq && va_eq;
            INV_GASID_VA:       clr_cond = (walk_ent.g || asid_eq) && va_eq;
            default:            clr_cond = 1'b0;
        endcase
        walk_clr = (state_q == S_INV_WALK) && clr_cond;
    end

    always_ff @(posedge clk) begin
        if (wr_en) ent_q[wr_idx] <= op_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_q <= '0;
        end else begin
            if (wr_en)    e_q[wr_idx]     <= 1'b1;
            if (walk_clr) e_q[walk_ptr_q] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_q   <= '0;
            walk_ptr_q <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_va_q   <= '0;
            done_err_q <= 1'b0;
        end else begin
            if (wr_en && is_fill) victim_q <= victim_q + 1'b1;
            if (accept && op_type == OP_INV) begin
                walk_ptr_q <= '0;
                inv_op_q   <= op_inv_op;
                inv_asid_q <= op_inv_asid;
                inv_va_q   <= op_inv_va;
                done_err_q <= op_inv_op > INV_OP_MAX;
            end else if (state_q == S_INV_WALK) begin
                walk_ptr_q <= walk_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_hit     <= 1'b0;
            res_idx     <= '0;
            res_entry   <= '0;
            op_err_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            res_hit     <= 1'b0;
            res_idx     <= '0;
            res_entry   <= '0;
            op_err_q    <= 1'b0;
            if (accept) begin
                case (op_type)
                    OP_SRCH: begin
                        res_valid_q <= 1'b1;
                        res_hit     <= sel_hit[NUM_LOOKUP];
                        res_idx     <= sel_idx[NUM_LOOKUP];
                    end
                    OP_RD: begin
                        res_valid_q <= 1'b1;
                        res_entry   <= ent_view[op_idx].e ? ent_view[op_idx] : '0;
                    end
                    OP_WR: begin
                        res_valid_q <= 1'b1;
                        op_err_q    <= !ps_ok;
                    end
                    OP_FILL: begin
                        res_valid_q <= 1'b1;
                        op_err_q    <= !ps_ok;
                        res_idx     <= victim_q;
                    end
                    OP_INV: begin
                        res_valid_q <= 1'b0;
                    end
                    default: begin
                        res_valid_q <= 1'b1;
                        op_err_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign res_valid = res_valid_q | (state_q == S_DONE);
    assign op_err    = op_err_q | ((state_q == S_DONE) & done_err_q);
    assign dbg_state = state_q;

endmodule

// File: doc/tlb_param.md
TLB_PARAM -- requirements
Module: tlb_param

Interface
REQ-001 Parameter NUM_ENTRIES, default 64: entry count, power of two, 16..256; IDXW = log2(NUM_ENTRIES).
REQ-002 Parameter NUM_LOOKUP, default 2: independent translation ports (fetch, memory).
REQ-003 Parameter ASIDW, default 10: ASID width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 lk_valid  in  NUM_LOOKUP  per-port lookup request.
REQ-007 lk_va  in  NUM_LOOKUP x 20  VA[31:12] per port.
REQ-008 csr_asid  in  ASIDW  current ASID, shared by all lookup ports.
REQ-009 lk_rsp_valid / lk_hit / lk_lo  out  NUM_LOOKUP x (1/1/tlb_lo_t)  registered lookup result, lo = {ppn[19:0], plv[1:0], mat[1:0], d, v}.
REQ-010 lk_ps  out  NUM_LOOKUP x 6  page size of the hit entry.
REQ-011 op_valid / op_ready  in / out  1 / 1  management handshake; accepted when both high.
REQ-012 op_type  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 reserved.
REQ-013 op_idx / op_entry / op_inv_op / op_inv_asid / op_inv_va  in  IDXW / tlb_entry_t / 5 / ASIDW / 19  operands.
REQ-014 res_valid / res_hit / res_idx / res_entry / op_err  out  1 / 1 / IDXW / tlb_entry_t / 1  management result.

Function
REQ-015 Entry {e, g, asid, vppn[31:13], ps ∈ {12, 21}, lo0, lo1}; lo0 selected by the odd bit = 0 (VA[12] when ps=12, VA[21] when ps=21), lo1 when it is 1.
REQ-016 Match: e=1, (g=1 or asid equal), VPPN compared on [31:13] for ps=12, on [31:22] for ps=21.
REQ-017 Lookup latency: exactly 1 cycle; the lk_* outputs are registered, and lk_rsp_valid follows lk_valid by 1 cycle.
REQ-018 Multiple hits: the lowest index wins (lookup and SRCH alike).
REQ-019 Miss: lk_hit=0, lk_lo=0, lk_ps=0.
REQ-020 SRCH: 1-cycle latency; res_hit and res_idx computed using csr_asid and op_entry.vppn.
REQ-021 RD: 1-cycle latency; res_entry = entry[op_idx]; if e=0, then res_entry=0 except e=0.
REQ-022 WR: writes op_entry to entry[op_idx]; pulses res_valid the next cycle.
REQ-023 FILL: writes op_entry to entry[victim]; victim is a round-robin counter that advances after each FILL, wraps NUM_ENTRIES-1 -> 0, and returns victim in res_idx.
REQ-024 WR/FILL with ps not in {12, 21}: entry not written; op_err pulses with res_valid.
REQ-025 FSM states: IDLE, INV_WALK, DONE.
REQ-026 IDLE: op_ready=1; accepting INV with inv_op 0-6 -> INV_WALK with walk pointer 0; inv_op >6 -> DONE with op_err=1.
REQ-027 INV_WALK: op_ready=0; one entry per cycle; pointer at NUM_ENTRIES-1 -> DONE.
REQ-028 DONE: res_valid=1 for 1 cycle, then -> IDLE.
REQ-029 INV clearing (e:=0) per inv_op: 0/1 all; 2 g=1; 3 g=0; 4 g=0 & asid match; 5 g=0 & asid & va match; 6 (g=1 | asid match) & va match.
REQ-030 Lookups continue during INV_WALK and see the partially walked array.
REQ-031 Same-cycle write and lookup: the lookup sees pre-write contents; the write is visible in the next cycle.
REQ-032 Reserved op_type: op_err=1 with res_valid, no state change.

Reset
REQ-033 rst clears every entry's e bit and victim counter, sets FSM=IDLE, and drives all outputs to 0 except op_ready=1.
REQ-034 rst during INV_WALK aborts the walk immediately; there is no res_valid afterwards.

Structure
REQ-035 Shared package tlb_pkg holds tlb_lo_t, tlb_entry_t, the op_type and inv_op encodings, and PS_4K=12 and PS_2M=21.
REQ-036 Sub-module tlb_match: combinational single-entry match plus odd-page select, instantiated NUM_ENTRIES x (NUM_LOOKUP+1) times.

Verification
REQ-037 Scenario: WR idx 5 {e=1, g=0, asid=3, vppn=0x12345, ps=12, lo1.ppn=0xABCDE}; then lookup VA=0x2468B000 with csr_asid=3 -> lk_hit=1, lk_lo.ppn=0xABCDE 1 cycle later.
REQ-038 Scenario: the same lookup with csr_asid=4 -> lk_hit=0, lk_lo=0.
REQ-039 Scenario: 65 FILLs on NUM_ENTRIES=64 -> res_idx sequence 0..63, then 0.
REQ-040 Scenario: INV op 4 asid=3 over a mix of g=1 and g=0 entries -> op_ready low 64 cycles, then res_valid, and only g=0 & asid=3 entries cleared.
REQ-041 Scenario: WR ps=14 -> op_err=1 and RD of that index unchanged; INV op 9 -> op_err=1 after 1 cycle.
REQ-042 Scenario: rst asserted mid-walk -> all lookups miss, op_ready=1, and no res_valid.
